adder_err_sweep: RTL
====================

Name: adder_err_sweep

Overview:
- Synthesizable sweep engine that sits directly upstream and downstream of an approximate adder under evaluation.
- It drives every operand pair into the adder's a/b inputs and samples the adder's sum output.
- It computes the exact reference sum internally and accumulates raw error statistics in hardware: error count, signed error sum, absolute error sum, squared error sum and maximum absolute error.
- Software or a thin testbench divides the raw totals to get ER/AE/MAE/MSE/RMSE/MEP.

Parameters:
- WIDTH, 8: operand width of the adder under test; the sum is WIDTH+1 bits.
- TOT_W, 2*WIDTH+1: width of the case counter and the error counter (holds 2^(2*WIDTH)).
- ERR_W, WIDTH+2: signed width of the per-pair error (approx minus exact).
- SUM_W, 3*WIDTH+2: signed width of the error-sum accumulator.
- SQ_W, 4*WIDTH+2: unsigned width of the squared-error accumulator.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep.
- approx_sum_in  in  WIDTH+1  combinational sum returned by the adder for a_out/b_out.
- a_out  out  WIDTH  operand A to the adder.
- b_out  out  WIDTH  operand B to the adder.
- busy  out  1  high while sweeping.
- done  out  1  high when the sweep is complete; results are valid.
- total_cases  out  TOT_W  pairs accumulated.
- err_count  out  TOT_W  pairs with a nonzero error.
- err_sum  out  SUM_W  signed sum of (approx - exact).
- abs_err_sum  out  SUM_W  sum of |error|, unsigned.
- sq_err_sum  out  SQ_W  sum of error squared.
- max_abs_err  out  ERR_W  largest |error| seen.

Behaviour:
- Reset: state=IDLE. a_out, b_out, busy, done and all accumulators are 0. Reset applied mid-sweep aborts immediately; the partial results are discarded.
- FSM has three states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 → clear all accumulators, a_out=0, b_out=0, go to RUN.
- RUN: busy=1, done=0.
  - On each rising edge, accumulate the pair currently on a_out/b_out using approx_sum_in sampled at that edge.
  - exact = a_out + b_out, zero-extended to WIDTH+1.
  - err = approx_sum_in - exact, computed sign-extended in ERR_W.
  - total_cases += 1; err_count += (err != 0); err_sum += err; abs_err_sum += |err|; sq_err_sum += err*err; max_abs_err = max(max_abs_err, |err|).
  - Operand order: b_out is the inner loop and a_out the outer loop. b_out increments each cycle; when b_out is all ones it wraps to 0 and a_out increments.
  - On the edge that accumulates a_out=b_out=all ones: go to DONE, and a_out/b_out wrap to 0.
  - start is ignored while in RUN.
- DONE: busy=0, done=1. All result outputs are held stable. start=1 → clear the accumulators and re-enter RUN exactly as from IDLE. done falls on that same edge.
- Latency:
  - If start is sampled at edge E0, pairs are accumulated at edges E1..E(2^(2*WIDTH)).
  - done is high after edge E(2^(2*WIDTH)), i.e. 65536 cycles after start for WIDTH=8.
- The adder's path from a_out/b_out to approx_sum_in is combinational within one cycle. There is no extra pipeline stage.
- Arithmetic:
  - No accumulator may overflow for any adder output in the 0..2^(WIDTH+1)-1 range; the widths above are sized for the worst case.
  - Use wrap-free sign extension throughout.
  - Squaring is done on |err| (WIDTH+1 bits unsigned).

Test Plan:
- Exact adder (approx_sum_in = a_out + b_out), WIDTH=8, start pulse → done after 65536 cycles. total_cases=65536; err_count=0; err_sum, abs_err_sum, sq_err_sum and max_abs_err all 0.
- approx_sum_in = a_out + b_out + 1 → err_count=65536, err_sum=65536, abs_err_sum=65536, sq_err_sum=65536, max_abs_err=1.
- approx_sum_in tied to 0 → err_count=65535, err_sum=-16711680, abs_err_sum=16711680, sq_err_sum=4977295360, max_abs_err=510.
- Assert rst 1000 cycles into a sweep → next cycle: busy=0, done=0, all outputs 0, a_out=b_out=0. A new start then yields the scenario-1 results.
- Pulse start again 500 cycles into RUN → ignored; done still arrives exactly 65536 cycles after the first start.
- From DONE, pulse start with approx_sum_in = a_out + b_out + 1 → done drops on that edge, accumulators restart at 0. Final results equal scenario 2, not the sum of two runs.

Source files
------------

// File: rtl/adder_err_sweep_if.sv
// Bus between the sweep engine and the approximate adder it characterises.
// The master side is the sweep engine; the slave side is the adder plus
// whatever issues start and collects results.
interface adder_err_sweep_if #(
    parameter int WIDTH = 8,
    parameter int TOT_W = 2*WIDTH+1,
    parameter int ERR_W = WIDTH+2,
    parameter int SUM_W = 3*WIDTH+2,
    parameter int SQ_W  = 4*WIDTH+2
);
    logic             start;
    logic [WIDTH:0]   approx_sum_in;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             busy;
    logic             done;
    logic [TOT_W-1:0] total_cases;
    logic [TOT_W-1:0] err_count;
    logic [SUM_W-1:0] err_sum;
    logic [SUM_W-1:0] abs_err_sum;
    logic [SQ_W-1:0]  sq_err_sum;
    logic [ERR_W-1:0] max_abs_err;

    modport master (
        input  start, approx_sum_in,
        output a_out, b_out, busy, done, total_cases, err_count,
               err_sum, abs_err_sum, sq_err_sum, max_abs_err
    );

    modport slave (
        output start, approx_sum_in,
        input  a_out, b_out, busy, done, total_cases, err_count,
               err_sum, abs_err_sum, sq_err_sum, max_abs_err
    );
endinterface

// File: rtl/adder_err_sweep.sv
// Exhaustive sweep engine for an approximate adder: walks every operand
// pair (b inner, a outer), compares the adder's combinational result with
// the exact sum and accumulates raw error statistics. Accumulators are sized
// so that no worst-case adder output can overflow them.
module adder_err_sweep #(
    parameter int WIDTH = 8,
    parameter int TOT_W = 2*WIDTH+1,
    parameter int ERR_W = WIDTH+2,
    parameter int SUM_W = 3*WIDTH+2,
    parameter int SQ_W  = 4*WIDTH+2
) (
    input  logic              clk,
    input  logic              rst,
    adder_err_sweep_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [TOT_W-1:0] total_q, total_d;
    logic [TOT_W-1:0] errCount_q, errCount_d;
    logic [SUM_W-1:0] errSum_q, errSum_d;
    logic [SUM_W-1:0] absSum_q, absSum_d;
    logic [SQ_W-1:0]  sqSum_q, sqSum_d;
    logic [ERR_W-1:0] maxAbs_q, maxAbs_d;

    logic [WIDTH:0]       exactSum;
    logic [ERR_W-1:0]     err;
    logic [ERR_W-1:0]     negErr;
    logic [ERR_W-1:0]     absErr;
    logic [2*WIDTH+1:0]   absWide;
    logic [2*WIDTH+1:0]   sqErr;

    // Error of the pair currently presented: both sums are zero-extended to
    // ERR_W before subtracting, so the signed result can never wrap.
    always_comb begin
        exactSum = {1'b0, a_q} + {1'b0, b_q};
        err      = {1'b0, bus.approx_sum_in} - {1'b0, exactSum};
        negErr   = '0 - err;
        absErr   = err[ERR_W-1] ? negErr : err;
        absWide  = {{WIDTH{1'b0}}, absErr};
        sqErr    = absWide * absWide;
    end

    // Next-state logic: start (from IDLE or DONE) clears everything and
    // enters RUN; RUN accumulates one pair per cycle and steps the operands.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        total_d    = total_q;
        errCount_d = errCount_q;
        errSum_d   = errSum_q;
        absSum_d   = absSum_q;
        sqSum_d    = sqSum_q;
        maxAbs_d   = maxAbs_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    a_d        = '0;
                    b_d        = '0;
                    total_d    = '0;
                    errCount_d = '0;
                    errSum_d   = '0;
                    absSum_d   = '0;
                    sqSum_d    = '0;
                    maxAbs_d   = '0;
                end
            end
            RUN: begin
                total_d    = total_q + TOT_W'(1);
                errCount_d = errCount_q + {{(TOT_W-1){1'b0}}, (err != '0)};
                errSum_d   = errSum_q + {{(SUM_W-ERR_W){err[ERR_W-1]}}, err};
                absSum_d   = absSum_q + {{(SUM_W-ERR_W){1'b0}}, absErr};
                sqSum_d    = sqSum_q + {{(SQ_W-2*WIDTH-2){1'b0}}, sqErr};
                if (absErr > maxAbs_q) begin
                    maxAbs_d = absErr;
                end
                b_d = b_q + WIDTH'(1);
                if (b_q == '1) begin
                    a_d = a_q + WIDTH'(1);
                    if (a_q == '1) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and accumulator registers; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            total_q    <= '0;
            errCount_q <= '0;
            errSum_q   <= '0;
            absSum_q   <= '0;
            sqSum_q    <= '0;
            maxAbs_q   <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            total_q    <= total_d;
            errCount_q <= errCount_d;
            errSum_q   <= errSum_d;
            absSum_q   <= absSum_d;
            sqSum_q    <= sqSum_d;
            maxAbs_q   <= maxAbs_d;
        end
    end

    assign bus.a_out       = a_q;
    assign bus.b_out       = b_q;
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.total_cases = total_q;
    assign bus.err_count   = errCount_q;
    assign bus.err_sum     = errSum_q;
    assign bus.abs_err_sum = absSum_q;
    assign bus.sq_err_sum  = sqSum_q;
    assign bus.max_abs_err = maxAbs_q;

endmodule
